usb_slavefifo_arbiter: RTL and testbench

- Sequences the FX2 synchronous slave-FIFO interface (USB_FD, USB_FIFOADR, USB_SLCS/SLOE/SLRD/SLWR, USB_FLAGx).
- Shares the interface between two local requesters:
  - the command/receive path, which drains EP2 OUT into a local FIFO write port;
  - the image upload path, which fills EP6 IN from a local FIFO read port.
- Arbitrates round-robin, bounds each burst, and inserts bus turnaround.
- Sits between the image capture/DDR3 read logic and the top-level USB pins. The top level owns the tri-state on USB_FD.

---
 rtl/usb_fifo_pkg.sv | 36 +++
 rtl/usb_slavefifo_arbiter_if.sv | 40 ++++
 rtl/usb_rr_arb.sv | 40 ++++
 rtl/usb_slavefifo_arbiter.sv | 140 ++++++++++++++
 tb/tb_usb_slavefifo_arbiter.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/usb_fifo_pkg.sv
// ============================================================================
// usb_fifo_pkg : shared state, endpoint and grant encodings for the FX2 arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package usb_fifo_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ADDR  = 3'd1,
    RD_BURST = 3'd2,
    RD_END   = 3'd3,
    WR_ADDR  = 3'd4,
    WR_BURST = 3'd5,
    WR_END   = 3'd6
  } state_t;

  localparam logic [1:0] EP2_ADDR   = 2'b00;
  localparam logic [1:0] EP6_ADDR   = 2'b10;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_RD   = 2'b01;
  localparam logic [1:0] GRANT_WR   = 2'b10;

  function automatic logic [1:0] state_grant(input state_t s);
    case (s)
      RD_ADDR, RD_BURST, RD_END: state_grant = GRANT_RD;
      WR_ADDR, WR_BURST, WR_END: state_grant = GRANT_WR;
      default:                   state_grant = GRANT_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_slavefifo_arbiter_if.sv
// ============================================================================
// usb_slavefifo_arbiter_if : FX2 slave-FIFO pins plus local rx/tx FIFO ports
// Rev 1.0
// ============================================================================
`default_nettype none

interface usb_slavefifo_arbiter_if;
  logic        USB_FLAGA;
  logic        USB_FLAGC;
  logic [15:0] USB_FD_I;
  logic [15:0] USB_FD_O;
  logic        USB_FD_OE;
  logic [1:0]  USB_FIFOADR;
  logic        USB_SLCS;
  logic        USB_SLOE;
  logic        USB_SLRD;
  logic        USB_SLWR;
  logic        rx_full;
  logic        rx_wr_en;
  logic [15:0] rx_data;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic        busy;
  logic [1:0]  grant;

  modport master (
    input  USB_FLAGA, USB_FLAGC, USB_FD_I, rx_full, tx_valid, tx_data,
    output USB_FD_O, USB_FD_OE, USB_FIFOADR, USB_SLCS, USB_SLOE, USB_SLRD, USB_SLWR,
           rx_wr_en, rx_data, tx_ready, busy, grant
  );

  modport slave (
    output USB_FLAGA, USB_FLAGC, USB_FD_I, rx_full, tx_valid, tx_data,
    input  USB_FD_O, USB_FD_OE, USB_FIFOADR, USB_SLCS, USB_SLOE, USB_SLRD, USB_SLWR,
           rx_wr_en, rx_data, tx_ready, busy, grant
  );
endinterface

`default_nettype wire

// File: rtl/usb_rr_arb.sv
// ============================================================================
// usb_rr_arb : two-way round-robin picker; favours the requester not last served
// Rev 1.0
// ============================================================================
`default_nettype none

module usb_rr_arb
  import usb_fifo_pkg::*;
(
  input  wire        clk,
  input  wire        rst,
  input  wire        req_rd,
  input  wire        req_wr,
  input  wire        take,
  output logic [1:0] pick
);

  logic [1:0] last_grant;

  always_comb begin
    pick = GRANT_NONE;
    if (req_rd && req_wr)
      pick = (last_grant == GRANT_RD) ? GRANT_WR : GRANT_RD;
    else if (req_rd)
      pick = GRANT_RD;
    else if (req_wr)
      pick = GRANT_WR;
  end

  // Starting from WR means the first contended grant after reset goes to RD.
  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= GRANT_WR;
    else if (take && (pick != GRANT_NONE))
      last_grant <= pick;
  end

endmodule

`default_nettype wire

// File: rtl/usb_slavefifo_arbiter.sv
// ============================================================================
// usb_slavefifo_arbiter : shares the FX2 slave FIFO between EP2 drain and EP6 fill
// Rev 1.0
// ============================================================================
`default_nettype none

module usb_slavefifo_arbiter
  import usb_fifo_pkg::*;
#(
  parameter int         MAX_BURST   = 256,
  parameter int         TURN        = 2,
  parameter logic [1:0] EP_OUT_ADDR = EP2_ADDR,
  parameter logic [1:0] EP_IN_ADDR  = EP6_ADDR
) (
  input wire FPGA_GCLK1,
  input wire CPU_RESET,
  usb_slavefifo_arbiter_if.master bus
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TURN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN - 1);

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] count;
  logic [TW-1:0] turn_cnt;
  logic          flag_a_q;
  logic          flag_c_q;
  logic          rd_ok;
  logic          wr_ok;
  logic          strobe;
  logic [1:0]    pick;

  assign rd_ok  = flag_a_q & ~bus.rx_full;
  assign wr_ok  = flag_c_q & bus.tx_valid;
  assign strobe = ((state == RD_BURST) && rd_ok) || ((state == WR_BURST) && wr_ok);

  usb_rr_arb u_arb (
    .clk    (FPGA_GCLK1),
    .rst    (CPU_RESET),
    .req_rd (rd_ok),
    .req_wr (wr_ok),
    .take   (state == IDLE),
    .pick   (pick)
  );

  always_ff @(posedge FPGA_GCLK1) begin
    if (CPU_RESET) begin
      state    <= IDLE;
      flag_a_q <= 1'b0;
      flag_c_q <= 1'b0;
      count    <= '0;
      turn_cnt <= '0;
    end else begin
      state    <= next_state;
      flag_a_q <= bus.USB_FLAGA;
      flag_c_q <= bus.USB_FLAGC;
      if (state == IDLE)
        count <= '0;
      else if (strobe && (count != CNT_MAX))
        count <= count + 1'b1;
      if ((state == RD_END) || (state == WR_END))
        turn_cnt <= turn_cnt + 1'b1;
      else
        turn_cnt <= '0;
    end
  end

  // A strobe issued with count at CNT_LAST is the final word of the burst.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (pick == GRANT_RD)      next_state = RD_ADDR;
        else if (pick == GRANT_WR) next_state = WR_ADDR;
      end
      RD_ADDR:  next_state = RD_BURST;
      RD_BURST: if (!rd_ok || (count == CNT_LAST)) next_state = RD_END;
      RD_END:   if (turn_cnt == TURN_LAST) next_state = IDLE;
      WR_ADDR:  next_state = WR_BURST;
      WR_BURST: if (!wr_ok || (count == CNT_LAST)) next_state = WR_END;
      WR_END:   if (turn_cnt == TURN_LAST) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.USB_FIFOADR = EP_OUT_ADDR;
    bus.USB_SLCS    = 1'b1;
    bus.USB_SLOE    = 1'b1;
    bus.USB_SLRD    = 1'b1;
    bus.USB_SLWR    = 1'b1;
    bus.USB_FD_OE   = 1'b0;
    bus.USB_FD_O    = '0;
    bus.rx_wr_en    = 1'b0;
    bus.tx_ready    = 1'b0;
    case (state)
      RD_ADDR: begin
        bus.USB_SLCS = 1'b0;
        bus.USB_SLOE = 1'b0;
      end
      RD_BURST: begin
        bus.USB_SLCS = 1'b0;
        bus.USB_SLOE = 1'b0;
        bus.USB_SLRD = ~rd_ok;
        bus.rx_wr_en = rd_ok;
      end
      RD_END: bus.USB_SLCS = 1'b0;
      WR_ADDR: begin
        bus.USB_FIFOADR = EP_IN_ADDR;
        bus.USB_SLCS    = 1'b0;
        bus.USB_FD_OE   = 1'b1;
        bus.USB_FD_O    = bus.tx_data;
      end
      WR_BURST: begin
        bus.USB_FIFOADR = EP_IN_ADDR;
        bus.USB_SLCS    = 1'b0;
        bus.USB_FD_OE   = 1'b1;
        bus.USB_FD_O    = bus.tx_data;
        bus.USB_SLWR    = ~wr_ok;
        bus.tx_ready    = wr_ok;
      end
      WR_END: begin
        bus.USB_FIFOADR = EP_IN_ADDR;
        bus.USB_SLCS    = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.rx_data = bus.USB_FD_I;
  assign bus.busy    = (state != IDLE);
  assign bus.grant   = state_grant(state);

endmodule

`default_nettype wire

// File: tb/tb_usb_slavefifo_arbiter.sv
// ============================================================================
// tb_usb_slavefifo_arbiter : directed checks of reset, read drain, burst limit,
// fairness, write burst and mid-burst reset.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_usb_slavefifo_arbiter;
  import usb_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  usb_slavefifo_arbiter_if bus ();
  usb_slavefifo_arbiter_if bus4 ();

  usb_slavefifo_arbiter dut (
    .FPGA_GCLK1 (clk),
    .CPU_RESET  (rst),
    .bus        (bus.master)
  );

  usb_slavefifo_arbiter #(.MAX_BURST(4)) dut4 (
    .FPGA_GCLK1 (clk),
    .CPU_RESET  (rst),
    .bus        (bus4.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int consumed, written, wr_en_cnt, first_oe, first_rd, end_cycles;
    int pulses, ready_cnt, last_wr, ng, viol, found;
    logic strobe;
    logic [31:0] rd_bits, en_bits;
    logic [1:0] prev_g, first_g;
    logic [1:0] seq [4];
    logic oe_log [32];
    logic [1:0] gr_log [32];

    bus.USB_FLAGA = 1'b1;  bus.USB_FLAGC = 1'b1;  bus.tx_valid = 1'b1;
    bus.rx_full   = 1'b0;  bus.USB_FD_I  = '0;    bus.tx_data  = 16'h1234;
    bus4.USB_FLAGA = 1'b0; bus4.USB_FLAGC = 1'b0; bus4.tx_valid = 1'b0;
    bus4.rx_full   = 1'b0; bus4.USB_FD_I  = '0;   bus4.tx_data  = '0;

    // Reset held with both requesters active
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_slcs",    bus.USB_SLCS, 1);
    chk("rst_sloe",    bus.USB_SLOE, 1);
    chk("rst_slrd",    bus.USB_SLRD, 1);
    chk("rst_slwr",    bus.USB_SLWR, 1);
    chk("rst_fd_oe",   bus.USB_FD_OE, 0);
    chk("rst_fd_o",    bus.USB_FD_O, 0);
    chk("rst_rx_wr",   bus.rx_wr_en, 0);
    chk("rst_tx_rdy",  bus.tx_ready, 0);
    chk("rst_busy",    bus.busy, 0);
    chk("rst_grant",   bus.grant, GRANT_NONE);
    chk("rst_fifoadr", bus.USB_FIFOADR, 2'b00);
    chk("rst_grant4",  bus4.grant, GRANT_NONE);

    // Read drain: 10 words available, almost-empty drops with one left
    cyc();
    bus.USB_FLAGC = 1'b0; bus.tx_valid = 1'b0; bus.USB_FLAGA = 1'b1;
    rst = 1'b0;
    consumed = 0; wr_en_cnt = 0; first_oe = -1; first_rd = -1; end_cycles = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      strobe = !bus.USB_SLRD;
      if (!bus.USB_SLOE && first_oe < 0) first_oe = c;
      if (strobe) begin
        if (first_rd < 0) begin
          first_rd = c;
          chk("rd_fifoadr", bus.USB_FIFOADR, 2'b00);
        end
        chk("rd_data", bus.rx_data, consumed);
        chk("rd_wr_en", bus.rx_wr_en, 1);
      end
      if (bus.rx_wr_en) wr_en_cnt++;
      if (bus.busy && bus.grant == GRANT_RD && bus.USB_SLOE) end_cycles++;
      cyc();
      if (strobe) begin
        consumed++;
        bus.USB_FD_I  = 16'(consumed);
        bus.USB_FLAGA = ((10 - consumed) > 1);
      end
    end
    chk("rd_count", wr_en_cnt, 10);
    chk("rd_oe_lead", first_rd - first_oe, 1);
    chk("rd_turn", end_cycles, 2);
    chk("rd_idle", bus.busy, 0);

    // Burst limit on the MAX_BURST=4 instance
    bus4.USB_FLAGA = 1'b1;
    rd_bits = '0; en_bits = '0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      rd_bits[c] = !bus4.USB_SLRD;
      en_bits[c] = bus4.rx_wr_en;
      cyc();
    end
    chk("burst_slrd", rd_bits, 32'h0078_7878);
    chk("burst_wr_en", en_bits, 32'h0078_7878);

    // Fairness: both requesters permanently eligible
    bus4.USB_FLAGC = 1'b1; bus4.tx_valid = 1'b1;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    ng = 0; viol = 0; prev_g = GRANT_NONE;
    for (int i = 0; i < 4; i++) seq[i] = GRANT_NONE;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus4.grant != prev_g && bus4.grant != GRANT_NONE && ng < 4) begin
        seq[ng] = bus4.grant;
        ng++;
      end
      prev_g = bus4.grant;
      if (bus4.USB_FD_OE && !bus4.USB_SLOE) viol++;
      if (!bus4.USB_SLRD && !bus4.USB_SLWR) viol++;
      cyc();
    end
    chk("fair_g0", seq[0], GRANT_RD);
    chk("fair_g1", seq[1], GRANT_WR);
    chk("fair_g2", seq[2], GRANT_RD);
    chk("fair_g3", seq[3], GRANT_WR);
    chk("fair_excl", viol, 0);
    bus4.USB_FLAGA = 1'b0; bus4.USB_FLAGC = 1'b0; bus4.tx_valid = 1'b0;

    // Write: three words of space, almost-full drops with one left
    written = 0; pulses = 0; ready_cnt = 0; last_wr = -1;
    bus.tx_valid = 1'b1; bus.tx_data = 16'hA5A0; bus.USB_FLAGC = 1'b1;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      strobe = !bus.USB_SLWR;
      if (strobe) begin
        if (pulses == 0) chk("wr_fifoadr", bus.USB_FIFOADR, 2'b10);
        chk("wr_fd_o", bus.USB_FD_O, 16'hA5A0 + written);
        chk("wr_ready", bus.tx_ready, 1);
        pulses++;
        last_wr = c;
      end
      if (bus.tx_ready) ready_cnt++;
      oe_log[c] = bus.USB_FD_OE;
      gr_log[c] = bus.grant;
      cyc();
      if (strobe) begin
        written++;
        bus.tx_data   = 16'hA5A0 + 16'(written);
        bus.USB_FLAGC = ((3 - written) > 1);
      end
    end
    chk("wr_pulses", pulses, 3);
    chk("wr_ready_cnt", ready_cnt, 3);
    if (last_wr >= 0 && last_wr < 30) begin
      chk("wr_oe_burst", oe_log[last_wr + 1], 1);
      chk("wr_oe_end", oe_log[last_wr + 2], 0);
      chk("wr_end_grant", gr_log[last_wr + 2], GRANT_WR);
    end else begin
      chk("wr_seen", 0, 1);
    end

    // Mid-burst reset during a write, with both sides eligible afterwards
    bus.USB_FLAGC = 1'b1; bus.tx_valid = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      @(negedge clk);
      if (!bus.USB_SLWR) found = 1;
    end
    chk("mid_strobe_seen", found, 1);
    rst = 1'b1;
    bus.USB_FLAGA = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_slwr",  bus.USB_SLWR, 1);
    chk("mid_fd_oe", bus.USB_FD_OE, 0);
    chk("mid_slcs",  bus.USB_SLCS, 1);
    chk("mid_busy",  bus.busy, 0);
    chk("mid_grant", bus.grant, GRANT_NONE);
    cyc();
    rst = 1'b0;
    first_g = GRANT_NONE;
    for (int c = 0; c < 10 && first_g == GRANT_NONE; c++) begin
      @(negedge clk);
      first_g = bus.grant;
    end
    chk("mid_first_grant", first_g, GRANT_RD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
